// File: rtl/tune_sequencer.sv
// rtl/tune_sequencer.sv - multi-tune ROM-driven stereo square-wave sequencer
module tune_sequencer #(
  parameter int          STATE_W     = 2,
  parameter int          STEP_W      = 6,
  parameter int          DIV_W       = 22,
  parameter int          TICK_CYCLES = 10_000_000,
  parameter logic [15:0] AMPLITUDE   = 16'h2000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [STATE_W-1:0]         state,
  output logic [STATE_W+STEP_W-1:0]  rom_addr,
  input  logic [5+2*DIV_W:0]         rom_data,
  output logic [15:0]                audio_left,
  output logic [15:0]                audio_right,
  output logic                       busy,
  output logic                       done
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [15:0] NEG_AMP = ~AMPLITUDE + 16'd1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_PLAY  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  logic [STATE_W-1:0] state_q;
  logic [2:0]         fsm;
  logic [STEP_W-1:0]  step;
  logic [TICK_W-1:0]  tick_cnt;
  logic [3:0]         beats;

  logic               w_end, w_loop;
  logic [3:0]         w_dur;
  logic [DIV_W-1:0]   new_div [2];
  logic [DIV_W-1:0]   div_q   [2];
  logic [DIV_W-1:0]   cnt_q   [2];
  logic               ph_q    [2];

  logic restart, mute, tick_wrap, load_div, clr_div;

  assign w_end      = rom_data[5+2*DIV_W];
  assign w_loop     = rom_data[4+2*DIV_W];
  assign w_dur      = rom_data[3+2*DIV_W:2*DIV_W];
  assign new_div[0] = rom_data[2*DIV_W-1:DIV_W];
  assign new_div[1] = rom_data[DIV_W-1:0];

  // A tune change while playing restarts from step 0 and silences at once.
  assign restart   = enable && (state != state_q);
  assign mute      = !enable || restart;
  assign tick_wrap = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
  assign load_div  = !mute && (fsm == S_LATCH) && !w_end;
  assign clr_div   = mute || ((fsm == S_LATCH) && w_end && !w_loop);

  assign rom_addr = {state_q, step};
  assign busy     = (fsm == S_FETCH) || (fsm == S_WAIT) ||
                    (fsm == S_LATCH) || (fsm == S_PLAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      fsm      <= S_IDLE;
      step     <= '0;
      tick_cnt <= '0;
      beats    <= '0;
      done     <= 1'b0;
    end else begin
      state_q <= state;
      if (!enable) begin
        fsm  <= S_IDLE;
        step <= '0;
        done <= 1'b0;
      end else if (restart) begin
        fsm  <= S_FETCH;
        step <= '0;
        done <= 1'b0;
      end else begin
        case (fsm)
          S_IDLE:  fsm <= S_FETCH;
          S_FETCH: fsm <= S_WAIT;
          S_WAIT:  fsm <= S_LATCH;
          S_LATCH: begin
            if (w_end && w_loop) begin
              step <= '0;
              fsm  <= S_FETCH;
            end else if (w_end) begin
              done <= 1'b1;
              fsm  <= S_HOLD;
            end else begin
              beats    <= (w_dur == 4'd0) ? 4'd1 : w_dur;
              tick_cnt <= '0;
              fsm      <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (tick_wrap) begin
              tick_cnt <= '0;
              beats    <= beats - 4'd1;
              if (beats == 4'd1) begin
                step <= step + STEP_W'(1);
                fsm  <= S_FETCH;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
          S_HOLD:  fsm <= S_HOLD;
          default: fsm <= S_IDLE;
        endcase
      end
    end
  end

  // Re-latching an unchanged divider keeps the waveform phase-continuous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        div_q[ch] <= '0;
        cnt_q[ch] <= '0;
        ph_q[ch]  <= 1'b0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (clr_div) begin
          div_q[ch] <= '0;
          cnt_q[ch] <= '0;
          ph_q[ch]  <= 1'b0;
        end else if (load_div && (new_div[ch] != div_q[ch])) begin
          div_q[ch] <= new_div[ch];
          cnt_q[ch] <= '0;
          ph_q[ch]  <= 1'b0;
        end else if (div_q[ch] == '0) begin
          cnt_q[ch] <= '0;
          ph_q[ch]  <= 1'b0;
        end else if (cnt_q[ch] == div_q[ch] - DIV_W'(1)) begin
          cnt_q[ch] <= '0;
          ph_q[ch]  <= ~ph_q[ch];
        end else begin
          cnt_q[ch] <= cnt_q[ch] + DIV_W'(1);
        end
      end
    end
  end

  function automatic logic [15:0] sample(input logic [DIV_W-1:0] d, input logic p);
    if (d == '0) return 16'd0;
    return p ? NEG_AMP : AMPLITUDE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_left  <= 16'd0;
      audio_right <= 16'd0;
    end else begin
      audio_left  <= mute ? 16'd0 : sample(div_q[0], ph_q[0]);
      audio_right <= mute ? 16'd0 : sample(div_q[1], ph_q[1]);
    end
  end

endmodule

// File: tb/tb_tune_sequencer.sv
// tb/tb_tune_sequencer.sv - randomized bench for tune_sequencer against a timeline model
module tb_tune_sequencer;

  localparam int STATE_W = 2;
  localparam int STEP_W  = 3;
  localparam int DIV_W   = 8;
  localparam int TICK    = 4;
  localparam int NT      = 4;
  localparam int STEPS   = 8;
  localparam int W       = 6 + 2 * DIV_W;
  localparam int LMAX    = 4096;
  localparam logic [15:0] AMP = 16'h2000;
  localparam logic [15:0] NEG = 16'hE000;

  logic                      clk;
  logic                      rst_n;
  logic                      enable;
  logic [STATE_W-1:0]        state;
  logic [STATE_W+STEP_W-1:0] rom_addr;
  logic [W-1:0]              rom_data;
  logic [15:0]               audio_left, audio_right;
  logic                      busy, done;

  tune_sequencer #(
    .STATE_W(STATE_W), .STEP_W(STEP_W), .DIV_W(DIV_W),
    .TICK_CYCLES(TICK), .AMPLITUDE(AMP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .state(state),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .audio_left(audio_left), .audio_right(audio_right),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] rom_mem [NT*STEPS];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Expected per-cycle behaviour of each tune, counted from its step-0 fetch.
  int          tl_step [NT][LMAX];
  logic        tl_busy [NT][LMAX];
  logic        tl_done [NT][LMAX];
  int          tl_dl   [NT][LMAX];
  int          tl_dr   [NT][LMAX];
  logic [15:0] tl_al   [NT][LMAX];
  logic [15:0] tl_ar   [NT][LMAX];

  int n_checks = 0;
  int n_fail   = 0;

  bit m_play;
  int m_s, m_t, m_sq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic e, input logic lp, input int dur,
                                      input int l, input int r);
    return {e, lp, 4'(dur), DIV_W'(l), DIV_W'(r)};
  endfunction

  function automatic logic [15:0] wave(input int d, input int age);
    if (d == 0) return 16'd0;
    return (((age / d) % 2) == 1) ? NEG : AMP;
  endfunction

  task automatic put(input int s, input int t, input int st, input logic b,
                     input logic dn, input int dl, input int dr);
    tl_step[s][t] = st;
    tl_busy[s][t] = b;
    tl_done[s][t] = dn;
    tl_dl[s][t]   = dl;
    tl_dr[s][t]   = dr;
  endtask

  task automatic build(input int s);
    int t, st, n, dl, dr, anc_l, anc_r;
    logic [W-1:0] w;
    logic [15:0] pl, pr;
    t = 0; st = 0; dl = 0; dr = 0;
    while (t < LMAX) begin
      w = rom_mem[s*STEPS+st];
      for (int k = 0; k < 3 && t < LMAX; k++) begin put(s, t, st, 1'b1, 1'b0, dl, dr); t++; end
      if (w[W-1] && w[W-2]) begin
        st = 0;
      end else if (w[W-1]) begin
        while (t < LMAX) begin put(s, t, st, 1'b0, 1'b1, 0, 0); t++; end
      end else begin
        dl = int'(w[2*DIV_W-1:DIV_W]);
        dr = int'(w[DIV_W-1:0]);
        n  = ((w[W-3:W-6] == 4'd0) ? 1 : int'(w[W-3:W-6])) * TICK;
        for (int k = 0; k < n && t < LMAX; k++) begin put(s, t, st, 1'b1, 1'b0, dl, dr); t++; end
        st = (st + 1) % STEPS;
      end
    end
    // Waveform age restarts whenever a channel's divider value changes.
    anc_l = 0; anc_r = 0; pl = 16'd0; pr = 16'd0;
    for (int i = 0; i < LMAX; i++) begin
      if (i > 0 && tl_dl[s][i] != tl_dl[s][i-1]) anc_l = i;
      if (i > 0 && tl_dr[s][i] != tl_dr[s][i-1]) anc_r = i;
      tl_al[s][i] = pl;
      tl_ar[s][i] = pr;
      pl = wave(tl_dl[s][i], i - anc_l);
      pr = wave(tl_dr[s][i], i - anc_r);
    end
  endtask

  task automatic check_outputs();
    int t;
    if (m_play) begin
      t = m_t;
      if (t >= LMAX) begin
        check_eq("horizon", 32'(t), 32'(LMAX - 1));
        t = LMAX - 1;
      end
      check_eq("audio_left",  32'(audio_left),  32'(tl_al[m_s][t]));
      check_eq("audio_right", 32'(audio_right), 32'(tl_ar[m_s][t]));
      check_eq("busy",        32'(busy),        32'(tl_busy[m_s][t]));
      check_eq("done",        32'(done),        32'(tl_done[m_s][t]));
      check_eq("rom_addr",    32'(rom_addr),    32'(m_sq * STEPS + tl_step[m_s][t]));
    end else begin
      check_eq("idle_left",  32'(audio_left),  32'd0);
      check_eq("idle_right", 32'(audio_right), 32'd0);
      check_eq("idle_busy",  32'(busy),        32'd0);
      check_eq("idle_done",  32'(done),        32'd0);
      check_eq("idle_addr",  32'(rom_addr),    32'(m_sq * STEPS));
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_play = 0; m_sq = 0;
    end else if (!enable) begin
      m_play = 0; m_sq = int'(state);
    end else begin
      if (!m_play || int'(state) != m_sq) begin
        m_play = 1; m_s = int'(state); m_t = 0;
      end else begin
        m_t++;
      end
      m_sq = int'(state);
    end
  endtask

  task automatic step_cycle(input logic en, input logic [STATE_W-1:0] st, input logic rn);
    enable = en; state = st; rst_n = rn;
    if (!rn) begin m_play = 0; m_sq = 0; end
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input logic en, input logic [STATE_W-1:0] st, input int n);
    for (int i = 0; i < n; i++) step_cycle(en, st, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; state = '0;
    m_play = 0; m_s = 0; m_t = 0; m_sq = 0;

    for (int i = 0; i < STEPS; i++) begin
      rom_mem[0*STEPS+i] = mk(1'b0, 1'b0, $urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 9));
      rom_mem[1*STEPS+i] = mk(1'b0, 1'b0, $urandom_range(0, 3), $urandom_range(1, 9), $urandom_range(1, 9));
      rom_mem[2*STEPS+i] = mk(1'b0, 1'b0, $urandom_range(0, 3), $urandom_range(1, 9), $urandom_range(1, 9));
      rom_mem[3*STEPS+i] = mk(1'b0, 1'b0, $urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 7));
    end
    rom_mem[0*STEPS+2] = mk(1'b0, 1'b0, 1, 3, 6);
    rom_mem[0*STEPS+3] = mk(1'b0, 1'b0, 2, 5, 6);
    rom_mem[1*STEPS+0] = mk(1'b0, 1'b0, 2, 3, 5);
    rom_mem[1*STEPS+1] = mk(1'b1, 1'b1, 0, 0, 0);
    rom_mem[2*STEPS+0] = mk(1'b0, 1'b0, 0, 0, 4);
    rom_mem[2*STEPS+1] = mk(1'b1, 1'b0, 0, 0, 0);
    rom_mem[3*STEPS+4] = mk(1'b1, 1'b1, 0, 0, 0);
    for (int s = 0; s < NT; s++) build(s);

    step_cycle(1'b1, 2'd1, 1'b0);
    step_cycle(1'b1, 2'd1, 1'b0);
    run(1'b1, 2'd1, 40);
    run(1'b1, 2'd2, 30);
    run(1'b1, 2'd1, 7);
    run(1'b1, 2'd0, 60);
    run(1'b0, 2'd0, 3);
    run(1'b1, 2'd0, 20);
    run(1'b1, 2'd3, 10);
    step_cycle(1'b1, 2'd3, 1'b0);
    run(1'b1, 2'd3, 30);

    for (int seg = 0; seg < 30; seg++) begin
      logic en;
      logic [STATE_W-1:0] st;
      int len;
      en  = ($urandom_range(0, 5) != 0);
      st  = STATE_W'($urandom_range(0, NT - 1));
      len = $urandom_range(1, 80);
      if ($urandom_range(0, 15) == 0) step_cycle(en, st, 1'b0);
      run(en, st, len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tune_sequencer.md
Name: tune_sequencer

Overview:
- Parametrised multi-tune audio sequencer; replaces the fixed per-tune counter, selector and buzzer chain with one block.
- A state input selects one of NUM_TUNES tunes.
- The block steps through note words held in an external synchronous ROM, timed by one internal base-tick divider.
- It generates stereo square-wave 16-bit samples that feed speaker_control directly.

Parameters:
- STATE_W, 2, width of state select; NUM_TUNES = 2**STATE_W.
- STEP_W, 6, step-index width; max 2**STEP_W notes per tune.
- DIV_W, 22, note divider width per channel.
- TICK_CYCLES, 10_000_000, clk cycles per base tick (10 Hz at 100 MHz).
- AMPLITUDE, 16'h2000, square-wave magnitude; must be < 16'h8000.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = play; 0 = mute and hold sequencer idle.
- state  in  STATE_W  tune select.
- rom_addr  out  STATE_W+STEP_W  {state_q, step}.
- rom_data  in  6+2*DIV_W  {end, loop, dur[3:0], div_left, div_right}; valid 1 cycle after rom_addr.
- audio_left  out  16  signed sample, left channel.
- audio_right  out  16  signed sample, right channel.
- busy  out  1  sequencer is fetching or playing.
- done  out  1  non-looping tune finished; held until restart.

Behaviour:
- Reset values: audio_left = audio_right = 0, rom_addr = 0, busy = 0, done = 0, FSM = IDLE, step = 0, tick counter = 0, channel counters = 0, phases = 0, latched dividers = 0.
- state is registered into state_q every cycle. A change (state ≠ state_q) while enable = 1 forces step = 0, done = 0, latched dividers = 0 (mute) and FSM = FETCH on the next cycle. This overrides every other transition.
- FSM transitions:
  - IDLE: enter when enable = 0. Outputs muted, busy = 0. Go to FETCH when enable = 1.
  - FETCH: drive rom_addr = {state_q, step}; go to WAIT.
  - WAIT: ROM latency cycle; go to LATCH.
  - LATCH: sample rom_data.
    - If end = 1 and loop = 1: step = 0, go to FETCH. Never plays the end word.
    - If end = 1 and loop = 0: dividers = 0, done = 1, go to HOLD.
    - Otherwise: latch div_left/div_right, load beat count = (dur == 0 ? 1 : dur), clear tick counter, go to PLAY.
  - PLAY: tick counter counts 0..TICK_CYCLES-1. Each wrap decrements beat count. When beat count reaches 0, step = step+1 and go to FETCH.
  - Step wrap: step wraps from 2**STEP_W-1 to 0 when no end word is present, which gives an implicit loop.
  - HOLD: silent, busy = 0, done = 1. Leave only on a state change or enable = 0.
- busy = 1 in FETCH, WAIT, LATCH and PLAY.
- Fetch overhead: 3 cycles per note between PLAY intervals. Previous dividers keep sounding through FETCH and WAIT; new dividers take effect the cycle after LATCH.
- Channel generator (each channel independent):
  - div = 0 means rest: sample = 0, counter and phase held at 0.
  - Otherwise counter counts 0..div-1. At div-1 it returns to 0 and phase toggles.
  - Sample = phase ? -AMPLITUDE : +AMPLITUDE (two's complement).
  - Tone frequency = clk / (2·div).
  - Latching a divider value different from the current one clears that channel's counter and phase in the same cycle. Latching an identical value lets the waveform continue uninterrupted.
- Samples are registered: 1-cycle latency from phase/divider to audio outputs.
- enable = 0 at any time: next cycle FSM = IDLE, audio = 0, done = 0, step = 0.
- rst_n asserted mid-operation: all registers return immediately to their reset values.

Test Plan:
- TICK_CYCLES = 4, ROM tune 1 = [{dur 2, L 3, R 5}, {end, loop}], enable = 1, state = 1:
  - rom_addr = 1<<STEP_W at FETCH.
  - audio_right toggles +AMPLITUDE / -AMPLITUDE every 5 cycles; audio_left toggles every 3 cycles.
  - Note lasts 8 cycles, then refetch at step 1, then restart at step 0.
- Tune 2 = [{dur 0, L 0, R 4}, {end, no loop}]:
  - Note plays for 4 cycles (dur 0 treated as 1); audio_left = 0 throughout.
  - Then done = 1, busy = 0, both outputs 0 until state changes.
- Switch state 1 -> 2 mid-PLAY:
  - Next cycle outputs = 0, step = 0, FSM = FETCH.
  - rom_addr = 2<<STEP_W; done stays 0.
- Consecutive notes with the same div_right = 6 and different div_left:
  - Right waveform shows no phase reset across the boundary; left counter restarts from 0.
- enable deasserted during PLAY, then reasserted:
  - audio = 0 and busy = 0 within 1 cycle.
  - Restart fetches step 0 of the current tune.
- rst_n pulsed low for 1 cycle during PLAY:
  - All outputs = 0 while rst_n = 0.
  - After release, FSM leaves IDLE and rom_addr = {state, 0} on the 2nd cycle.
